// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions.
// Holds the sample widths, the lane count, the butterfly sequencer state
// encoding and the twiddle-select codes that the multiplier decodes.
package fft_pkg;

  localparam int FFT_DIN_WIDTH  = 10;  // input sample, signed <4.6>
  localparam int FFT_WIDTH      = 11;  // butterfly output, signed <5.6>
  localparam int FFT_LANES      = 16;
  localparam int FFT_PAIR_DIST  = 8;

  typedef enum logic {
    FILL = 1'b0,
    CALC = 1'b1
  } bf_state_t;

  // Twiddle select codes: one per quarter of the CALC half-frame.
  localparam logic [1:0] SEL_Q0 = 2'd0;
  localparam logic [1:0] SEL_Q1 = 2'd1;
  localparam logic [1:0] SEL_Q2 = 2'd2;
  localparam logic [1:0] SEL_Q3 = 2'd3;

endpackage

// File: rtl/bfly_buf.sv
// Half-frame buffer for the radix-2 butterfly.
// PAIR_DIST entries, each holding all DEPTH lanes of {Q,R}.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write entry index
//   i_wdata  lanes to store, lane g = {Q,R}
//   i_raddr  read entry index (combinational read)
//   o_rdata  entry at i_raddr
// Storage is not reset; the sequencer never reads an entry before writing it
// in the same frame.
module bfly_buf #(
  parameter int PAIR_DIST = 8,
  parameter int DEPTH     = 16,
  parameter int DIN_WIDTH = 10,
  localparam int AW       = $clog2(PAIR_DIST)
) (
  input  logic                                clk,
  input  logic                                i_we,
  input  logic [AW-1:0]                       i_waddr,
  input  logic [DEPTH-1:0][2*DIN_WIDTH-1:0]   i_wdata,
  input  logic [AW-1:0]                       i_raddr,
  output logic [DEPTH-1:0][2*DIN_WIDTH-1:0]   o_rdata
);

  logic [DEPTH-1:0][2*DIN_WIDTH-1:0] r_mem [PAIR_DIST];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bfly_fac8_1.sv
// Radix-2 butterfly and sequencer feeding the mul_fac8_1 twiddle stage.
// The first PAIR_DIST beats of a frame are buffered; each of the next
// PAIR_DIST beats is butterflied against the buffered beat of the same index,
// all lanes in parallel. Results are registered (1-cycle latency).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   din_valid, din_sof  input beat valid / first beat of frame
//   din_R, din_Q        DEPTH lanes of signed DIN_WIDTH samples
//   en                  output beat valid (multiplier enable)
//   select              twiddle select, top two bits of the CALC counter
//   dout_sof            first output beat of a frame
//   dout_{R,Q}_{add,sub} DEPTH lanes of signed WIDTH butterfly results
// Lane data is two's complement packed per lane.
module bfly_fac8_1
  import fft_pkg::*;
#(
  parameter int DIN_WIDTH = FFT_DIN_WIDTH,
  parameter int WIDTH     = FFT_WIDTH,
  parameter int DEPTH     = FFT_LANES,
  parameter int PAIR_DIST = FFT_PAIR_DIST
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             din_valid,
  input  logic                             din_sof,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]  din_R,
  input  logic [DEPTH-1:0][DIN_WIDTH-1:0]  din_Q,
  output logic                             en,
  output logic [1:0]                       select,
  output logic                             dout_sof,
  output logic [DEPTH-1:0][WIDTH-1:0]      dout_R_add,
  output logic [DEPTH-1:0][WIDTH-1:0]      dout_R_sub,
  output logic [DEPTH-1:0][WIDTH-1:0]      dout_Q_add,
  output logic [DEPTH-1:0][WIDTH-1:0]      dout_Q_sub
);

  localparam int CW = $clog2(PAIR_DIST);

  bf_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_wr_en;
  logic [CW-1:0]     w_wr_idx;
  logic              w_calc_beat;
  logic              w_last;

  logic [DEPTH-1:0][2*DIN_WIDTH-1:0] w_wdata, w_rdata;
  logic [DEPTH-1:0][WIDTH-1:0]       w_r_add, w_r_sub, w_q_add, w_q_sub;

  logic                              r_en, r_sof;
  logic [1:0]                        r_select;
  logic [DEPTH-1:0][WIDTH-1:0]       r_r_add, r_r_sub, r_q_add, r_q_sub;

  // ---------------- sequencer ----------------
  assign w_last = (r_cnt == CW'(PAIR_DIST-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_cnt;
    w_calc_beat = 1'b0;
    if (din_valid) begin
      if (din_sof) begin
        // Start-of-frame overrides everything: the beat becomes entry 0 of a
        // fresh fill and any partial frame is dropped without output.
        w_wr_en     = 1'b1;
        w_wr_idx    = '0;
        w_state_nxt = FILL;
        w_cnt_nxt   = CW'(1);
      end else begin
        w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
        case (r_state)
          FILL: begin
            w_wr_en = 1'b1;
            if (w_last) w_state_nxt = CALC;
          end
          CALC: begin
            w_calc_beat = 1'b1;
            if (w_last) w_state_nxt = FILL;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- buffer ----------------
  bfly_buf #(
    .PAIR_DIST (PAIR_DIST),
    .DEPTH     (DEPTH),
    .DIN_WIDTH (DIN_WIDTH)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_idx),
    .i_wdata (w_wdata),
    .i_raddr (r_cnt),
    .o_rdata (w_rdata)
  );

  // ---------------- per-lane butterfly ----------------
  // One growth bit: add/sub of two DIN_WIDTH values always fits in WIDTH,
  // so plain modular arithmetic on sign-extended operands is exact.
  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    logic [WIDTH-1:0] w_ar, w_aq, w_br, w_bq;

    assign w_wdata[g] = {din_Q[g], din_R[g]};

    assign w_ar = {{(WIDTH-DIN_WIDTH){w_rdata[g][DIN_WIDTH-1]}},   w_rdata[g][DIN_WIDTH-1:0]};
    assign w_aq = {{(WIDTH-DIN_WIDTH){w_rdata[g][2*DIN_WIDTH-1]}}, w_rdata[g][2*DIN_WIDTH-1:DIN_WIDTH]};
    assign w_br = {{(WIDTH-DIN_WIDTH){din_R[g][DIN_WIDTH-1]}},     din_R[g]};
    assign w_bq = {{(WIDTH-DIN_WIDTH){din_Q[g][DIN_WIDTH-1]}},     din_Q[g]};

    assign w_r_add[g] = w_ar + w_br;
    assign w_r_sub[g] = w_ar - w_br;
    assign w_q_add[g] = w_aq + w_bq;
    assign w_q_sub[g] = w_aq - w_bq;
  end

  // ---------------- output registers ----------------
  // Everything but en holds between CALC beats so the multiplier sees stable
  // operands when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_sof    <= 1'b0;
      r_select <= SEL_Q0;
      r_r_add  <= '0;
      r_r_sub  <= '0;
      r_q_add  <= '0;
      r_q_sub  <= '0;
    end else begin
      r_en <= w_calc_beat;
      if (w_calc_beat) begin
        r_sof    <= (r_cnt == '0);
        r_select <= r_cnt[CW-1 -: 2];
        r_r_add  <= w_r_add;
        r_r_sub  <= w_r_sub;
        r_q_add  <= w_q_add;
        r_q_sub  <= w_q_sub;
      end
    end
  end

  assign en         = r_en;
  assign select     = r_select;
  assign dout_sof   = r_sof;
  assign dout_R_add = r_r_add;
  assign dout_R_sub = r_r_sub;
  assign dout_Q_add = r_q_add;
  assign dout_Q_sub = r_q_sub;

endmodule

// File: tb/tb_bfly_fac8_1.sv
// Directed bench for bfly_fac8_1: inputs change on the falling edge, the DUT
// samples on the rising edge, outputs are checked on the next falling edge.
module tb_bfly_fac8_1;
  import fft_pkg::*;

  localparam int DW = 10;
  localparam int W  = 11;
  localparam int L  = 16;
  localparam int PD = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 din_valid, din_sof;
  logic [L-1:0][DW-1:0] din_R, din_Q;
  logic                 en, dout_sof;
  logic [1:0]           select;
  logic [L-1:0][W-1:0]  dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bfly_fac8_1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_sof    (din_sof),
    .din_R      (din_R),
    .din_Q      (din_Q),
    .en         (en),
    .select     (select),
    .dout_sof   (dout_sof),
    .dout_R_add (dout_R_add),
    .dout_R_sub (dout_R_sub),
    .dout_Q_add (dout_Q_add),
    .dout_Q_sub (dout_Q_sub)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int r, input int q);
    for (int i = 0; i < L; i++) begin
      din_R[i] = DW'(r);
      din_Q[i] = DW'(q);
    end
  endtask

  // Present one beat and advance to the next falling edge.
  task automatic step(input logic v, input logic s);
    din_valid = v;
    din_sof   = s;
    @(negedge clk);
  endtask

  task automatic chk_lanes(input string tag, input int ra, input int rs, input int qa, input int qs);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("%s_Radd%0d", tag, i), $signed(dout_R_add[i]), ra);
      chk($sformatf("%s_Rsub%0d", tag, i), $signed(dout_R_sub[i]), rs);
      chk($sformatf("%s_Qadd%0d", tag, i), $signed(dout_Q_add[i]), qa);
      chk($sformatf("%s_Qsub%0d", tag, i), $signed(dout_Q_sub[i]), qs);
    end
  endtask

  task automatic idle_gaps(input string tag, input int gap, input int hold_ra);
    for (int g = 0; g < gap; g++) begin
      set_all(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      step(1'b0, 1'b0);
      chk({tag, "_gap_en"}, en, 0);
      chk({tag, "_gap_hold"}, $signed(dout_R_add[0]), hold_ra);
    end
  endtask

  task automatic fill_phase(input string tag, input logic sof1, input int fr, input int fq,
                            input int n, input int gap, input int hold_ra);
    for (int k = 0; k < n; k++) begin
      set_all(fr, fq);
      step(1'b1, sof1 && (k == 0));
      chk({tag, "_fill_en"}, en, 0);
      idle_gaps(tag, gap, hold_ra);
    end
  endtask

  task automatic calc_phase(input string tag, input int n, input int cr, input int cq,
                            input int ra, input int rs, input int qa, input int qs, input int gap);
    for (int k = 0; k < n; k++) begin
      set_all(cr, cq);
      step(1'b1, 1'b0);
      chk($sformatf("%s_en%0d", tag, k), en, 1);
      chk($sformatf("%s_sel%0d", tag, k), select, k / 2);
      chk($sformatf("%s_sof%0d", tag, k), dout_sof, (k == 0) ? 1 : 0);
      chk_lanes($sformatf("%s_b%0d", tag, k), ra, rs, qa, qs);
      idle_gaps(tag, gap, ra);
    end
  endtask

  initial begin
    din_valid = 1'b0;
    din_sof   = 1'b0;
    set_all(0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_en", en, 0);
    chk("rst_sel", select, 0);
    chk("rst_sof", dout_sof, 0);
    chk_lanes("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous frame: A = 1.0 + 0j, B = 0.5 - 0.5j
    fill_phase("cont", 1'b1, 64, 0, PD, 0, 0);
    calc_phase("cont", PD, 32, -32, 96, 32, -32, 32, 0);
    set_all(0, 0);
    step(1'b0, 1'b0);
    chk("cont_idle_en", en, 0);
    chk("cont_idle_hold", $signed(dout_R_add[0]), 96);
    chk("cont_idle_sel", select, 3);

    // Extremes, frames back to back without sof
    fill_phase("ext1", 1'b0, 511, 511, PD, 0, 96);
    calc_phase("ext1", PD, -512, -512, -1, 1023, -1, 1023, 0);
    fill_phase("ext2", 1'b0, -512, -512, PD, 0, -1);
    calc_phase("ext2", PD, -512, -512, -1024, 0, -1024, 0, 0);

    // Gapped input: valid pattern 1,0,0,1,0,0...
    fill_phase("gap", 1'b1, 64, 0, PD, 2, -1024);
    calc_phase("gap", PD, 32, -32, 96, 32, -32, 32, 2);

    // sof during CALC cnt=3 restarts the fill
    fill_phase("sofa", 1'b1, 64, 0, PD, 0, 96);
    calc_phase("sofa", 3, 32, -32, 96, 32, -32, 32, 0);
    set_all(10, 20);
    step(1'b1, 1'b1);
    chk("sof_beat_en", en, 0);
    fill_phase("sofb", 1'b0, 10, 20, PD - 1, 0, 96);
    calc_phase("sofc", PD, 4, 6, 14, 6, 26, 14, 0);

    // Reset during CALC cnt=5, then a frame with no sof
    fill_phase("rst", 1'b1, 64, 0, PD, 0, 14);
    calc_phase("rst", 5, 32, -32, 96, 32, -32, 32, 0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_en", en, 0);
    chk("arst_sel", select, 0);
    chk("arst_sof", dout_sof, 0);
    chk_lanes("arst", 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_phase("post", 1'b0, 100, -100, PD, 0, 0);
    calc_phase("post", PD, -50, 50, 50, 150, -50, -150, 0);

    // Per-lane distinctness: A = i, B = 2i
    for (int k = 0; k < PD; k++) begin
      for (int i = 0; i < L; i++) begin
        din_R[i] = DW'(i);
        din_Q[i] = '0;
      end
      step(1'b1, k == 0);
    end
    for (int i = 0; i < L; i++) begin
      din_R[i] = DW'(2 * i);
      din_Q[i] = '0;
    end
    step(1'b1, 1'b0);
    chk("lane_en", en, 1);
    for (int i = 0; i < L; i++) begin
      chk($sformatf("lane_Radd%0d", i), $signed(dout_R_add[i]), 3 * i);
      chk($sformatf("lane_Rsub%0d", i), $signed(dout_R_sub[i]), -i);
      chk($sformatf("lane_Qadd%0d", i), $signed(dout_Q_add[i]), 0);
    end
    for (int k = 1; k < PD; k++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("end_en", en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
